// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access ops, FSM states, alignment check.
// Pure definitions; no timing or flow control of its own.
package lsu_pkg;

  localparam int LSU_W = 32;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2,
    ST_WRITE = 2'd3
  } lsu_state_e;

  function automatic logic lsu_is_load(input lsu_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic lsu_misaligned(input lsu_op_e op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Zero latency, no flow control.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [LSU_W-1:0] i_word,
  input  logic [15:0]      i_wdata,
  input  logic [1:0]       i_byte_off,
  input  lsu_op_e          i_op,
  output logic [LSU_W-1:0] o_load_data,
  output logic [LSU_W-1:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_byte_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load_data = i_word;
    case (i_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'h000000, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'h0000, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Only the addressed lane changes; the rest of the old word is preserved.
  always_comb begin
    o_store_word = i_word;
    case (i_op)
      OP_SB: begin
        case (i_byte_off)
          2'd0: o_store_word[7:0]   = i_wdata[7:0];
          2'd1: o_store_word[15:8]  = i_wdata[7:0];
          2'd2: o_store_word[23:16] = i_wdata[7:0];
          2'd3: o_store_word[31:24] = i_wdata[7:0];
          default: o_store_word = i_word;
        endcase
      end
      OP_SH: begin
        if (i_byte_off[1]) o_store_word[31:16] = i_wdata;
        else               o_store_word[15:0]  = i_wdata;
      end
      default: o_store_word = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only memory; loads 2 cycles, SW 2, SH/SB 3 (RMW), faults 1.
// req_ready is low while an access is in flight; responses are single-cycle pulses with no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_misaligned,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_control_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        r_state, w_state_nxt;
  lsu_op_e           r_op;
  logic [DATA_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [DATA_W-1:0] r_merged;
  logic [RD_W-1:0]   r_rd;
  logic              r_resp_valid, r_resp_misaligned;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [RD_W-1:0]   r_resp_rd;

  lsu_op_e           w_req_op;
  logic              w_xfer, w_misaligned;
  logic [DATA_W-1:0] w_load_data, w_store_word;

  assign w_req_op     = lsu_op_e'(req_op);
  assign w_xfer       = req_valid && req_ready;
  assign w_misaligned = lsu_misaligned(w_req_op, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .i_word       (mem_read_data),
    .i_wdata      (r_wdata),
    .i_byte_off   (r_addr[1:0]),
    .i_op         (r_op),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Memory-side outputs depend only on state and latched request fields.
  always_comb begin
    w_state_nxt       = r_state;
    req_ready         = 1'b0;
    mem_address       = '0;
    mem_write_data    = '0;
    mem_control_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_xfer && !w_misaligned) begin
          if (lsu_is_load(w_req_op))  w_state_nxt = ST_LOAD;
          else if (w_req_op == OP_SW) w_state_nxt = ST_WRITE;
          else                        w_state_nxt = ST_MERGE;
        end
      end
      ST_LOAD: begin
        mem_address = {2'b00, r_addr[DATA_W-1:2]};
        w_state_nxt = ST_IDLE;
      end
      ST_MERGE: begin
        mem_address = {2'b00, r_addr[DATA_W-1:2]};
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        mem_address       = {2'b00, r_addr[DATA_W-1:2]};
        mem_write_data    = r_merged;
        mem_control_write = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_op              <= OP_LW;
      r_addr            <= '0;
      r_wdata           <= '0;
      r_merged          <= '0;
      r_rd              <= '0;
      r_resp_valid      <= 1'b0;
      r_resp_misaligned <= 1'b0;
      r_resp_rdata      <= '0;
      r_resp_rd         <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_resp_valid      <= 1'b0;
      r_resp_misaligned <= 1'b0;
      r_resp_rdata      <= '0;
      r_resp_rd         <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_op     <= w_req_op;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata[15:0];
            r_merged <= req_wdata;
            r_rd     <= req_rd;
            if (w_misaligned) begin
              r_resp_valid      <= 1'b1;
              r_resp_misaligned <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_resp_rd    <= r_rd;
        end
        ST_MERGE: r_merged     <= w_store_word;
        ST_WRITE: r_resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_rd         = r_resp_rd;
  assign resp_misaligned = r_resp_misaligned;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the EX stage and the word-addressed `data_memory`, turning byte-addressed load/store requests into word accesses. Performs byte/halfword extraction with sign/zero extension on loads. Performs read-modify-write for sub-word stores, since `data_memory` only writes whole words. Flags misaligned accesses without touching memory, and returns one response per request to the writeback stage.

## Interface
- `DATA_W`, 32: data and address width in bits.
- `RD_W`, 5: destination register index width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  EX presents an access.
- `req_ready`  out  1  unit can accept; transfer when `req_valid && req_ready`.
- `req_op`  in  3  LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- `req_addr`  in  DATA_W  byte address.
- `req_wdata`  in  DATA_W  store data; sub-word stores use low bits.
- `req_rd`  in  RD_W  load destination register.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and faults.
- `resp_rd`  out  RD_W  echoed `req_rd` for loads; 0 otherwise.
- `resp_misaligned`  out  1  access was misaligned and not performed.
- `mem_address`  out  DATA_W  word index `{2'b00, addr[31:2]}`.
- `mem_write_data`  out  DATA_W  word to store.
- `mem_control_write`  out  1  memory write enable; level-sensitive at memory.
- `mem_read_data`  in  DATA_W  combinational read data for `mem_address`.

## Operation
- Little-endian lanes: byte at `addr[1:0]=k` occupies bits `[8k+7:8k]`; halfword at `addr[1]=h` occupies `[16h+15:16h]`.
- Misaligned: halfword ops with `addr[0]=1`; word ops with `addr[1:0]!=0`. Misaligned requests never drive `mem_control_write`.
- FSM states: IDLE, LOAD, MERGE, WRITE.
- IDLE: `req_ready=1`. On transfer, latch op/addr/wdata/rd.
  - Misaligned request → stay in IDLE, fault response next cycle.
  - Load → LOAD.
  - SW → WRITE with merged word = wdata.
  - SH/SB → MERGE.
- LOAD: drive `mem_address` from latched addr, extract lane and extend (LB/LH sign, LBU/LHU zero). Register response; → IDLE.
- MERGE: read word, replace target lane with low bits of wdata, register merged word; → WRITE.
- WRITE: `mem_control_write=1`, `mem_write_data`=merged word; → IDLE, store response.
- `req_ready=0` in LOAD, MERGE and WRITE; `req_valid` is ignored there and upstream holds the request.
- Outside LOAD/MERGE/WRITE, `mem_address=0` and `mem_write_data=0`. `mem_control_write` is high only in WRITE.
- Memory-side outputs come from state and latched registers only, never from `req_*`, so they are glitch-free for the level-sensitive memory.

## Timing
- Request accepted in cycle 0. `resp_valid` is high for exactly one cycle at:
  - misaligned: cycle 1
  - load: cycle 2
  - SW: cycle 2
  - SH/SB: cycle 3
- `req_ready` returns high in the same cycle as `resp_valid`, so back-to-back requests are accepted then.
- Reset values: state IDLE, `req_ready=1`, all other outputs 0.
- Reset asserted mid-operation:
  - state returns to IDLE immediately and asynchronously
  - `mem_control_write` drops immediately
  - the pending response is discarded
  - a partial RMW never writes
- Memory range is not checked; upper address bits pass through.

## Structure
- Shared package `lsu_pkg`: op encodings, FSM state encodings, misalignment function.
- One combinational sub-module, `lsu_lane_align`, containing:
  - load extract/extend: (word, addr[1:0], op) → data
  - store merge: (old word, wdata, addr[1:0], op) → word
- FSM and registers live in `load_store_unit`, driving `data_memory` directly.

## Test plan
- **SW then LW:** SW addr 0x10 data 0xDEADBEEF; `mem_control_write` high only in cycle 1 at `mem_address=4`. LW 0x10 gives `resp_rdata=0xDEADBEEF` in cycle 2 with echoed rd.
- **Sign/zero extension:** with word 0x80F17F00 at 0x20:
  - LB 0x22 → 0xFFFFFFF1
  - LBU 0x22 → 0x000000F1
  - LH 0x22 → 0xFFFF80F1
  - LHU 0x20 → 0x00007F00
- **SB RMW:** SB 0x21 data 0x1234ABCD onto 0x11223344 → word 0x1122CD44. Write occurs in cycle 2, response in cycle 3, `req_ready` low in cycles 1–2.
- **Misalignment:** LW 0x13, SH 0x15 and LH 0x01 each give `resp_misaligned=1` in cycle 1. `mem_control_write` never rises and memory contents are unchanged.
- **Backpressure:** `req_valid` held with a new SW during an SH's MERGE/WRITE; the second request is accepted only in the SH response cycle, and both writes land.
- **Reset mid-RMW:** `rst_n` low during MERGE; no write occurs, no `resp_valid`, outputs are 0. After release, the next LW is served normally.
